// File: rtl/inst_fetch_buffer_pkg.sv
// Shared constants and types for the instruction fetch buffer.
// Holds reset PC, request size encoding, buffer sizing and the FIFO entry.
package inst_fetch_buffer_pkg;

  localparam logic [31:0] IFB_RESET_PC     = 32'hBFC00000;
  localparam logic [1:0]  IFB_INST_SIZE    = 2'b10;
  localparam int          IFB_FIFO_DEPTH   = 4;
  localparam int          IFB_MAX_INFLIGHT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_sync_fifo.sv
// Synchronous FIFO with flush; head is a registered read, no bypass.
// Ports: clk, reset, flush, push/push_data, pop, head, empty, count.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= nxt(rd_ptr);
      end
      cnt <= cnt + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch front end: sram-like request issue, in-order tag queue, inst FIFO.
// Ports: clk/reset, redirect, inst_* bridge channel, out_* decode handshake.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = IFB_RESET_PC,
  parameter int          FIFO_DEPTH   = IFB_FIFO_DEPTH,
  parameter int          MAX_INFLIGHT = IFB_MAX_INFLIGHT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int TW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int TCW = $clog2(MAX_INFLIGHT + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [31:0] fetch_pc;
  logic        hold;
  logic [31:0] hold_addr;
  logic        hold_stale;

  logic [31:0]             tag_pc [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] tag_kill;
  logic [MAX_INFLIGHT-1:0] kill_next;
  logic [TW-1:0]           tag_head;
  logic [TW-1:0]           tag_tail;
  logic [TCW-1:0]          tag_cnt;

  logic         can_issue;
  logic         accept;
  logic         accept_kill;
  logic         resp;
  logic         resp_live;
  logic         fifo_pop;
  logic         fifo_empty;
  logic [FCW-1:0] fifo_cnt;
  fetch_entry_t push_entry;
  fetch_entry_t fifo_head;
  logic [1:0]   unused_redirect_lsb;

  function automatic logic [TW-1:0] tag_nxt(
    input logic [TW-1:0] p
  );
    return (p == TW'(MAX_INFLIGHT - 1)) ? '0 : p + TW'(1);
  endfunction

  assign unused_redirect_lsb = redirect_pc[1:0];

  assign inst_wr    = 1'b0;
  assign inst_size  = IFB_INST_SIZE;
  assign inst_wdata = '0;

  // Credit covers both outstanding responses and buffered words,
  // so every accepted request is guaranteed a FIFO slot.
  assign can_issue =
    (32'(tag_cnt) < 32'(MAX_INFLIGHT)) &&
    (32'(tag_cnt) + 32'(fifo_cnt) < 32'(FIFO_DEPTH));

  // A request that has been raised stays up, at its original
  // address, until the bridge takes it.
  assign inst_req  = ~reset & (hold | can_issue);
  assign inst_addr = hold ? hold_addr : fetch_pc;
  assign accept    = inst_req & inst_addr_ok;

  // A held request that outlived a redirect is fetched but discarded.
  assign accept_kill = redirect_valid | (hold & hold_stale);

  assign resp      = inst_data_ok & (tag_cnt != '0);
  assign resp_live = resp & ~tag_kill[tag_head] & ~redirect_valid;

  assign push_entry = '{pc: tag_pc[tag_head], inst: inst_rdata};

  assign out_valid = ~reset & ~fifo_empty;
  assign fifo_pop  = out_valid & out_ready & ~redirect_valid;
  assign out_pc    = fifo_head.pc;
  assign out_inst  = fifo_head.inst;

  always_comb begin
    kill_next = tag_kill;
    if (redirect_valid) begin
      kill_next = '1;
    end
    if (accept) begin
      kill_next[tag_tail] = accept_kill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      hold       <= 1'b0;
      hold_addr  <= '0;
      hold_stale <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (accept & ~(hold & hold_stale)) begin
        fetch_pc <= inst_addr + 32'd4;
      end
      hold       <= inst_req & ~inst_addr_ok;
      hold_addr  <= inst_addr;
      hold_stale <= inst_req & ~inst_addr_ok &
                    ((hold & hold_stale) | redirect_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_head <= '0;
      tag_tail <= '0;
      tag_cnt  <= '0;
      tag_kill <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        tag_pc[i] <= '0;
      end
    end else begin
      tag_kill <= kill_next;
      if (accept) begin
        tag_pc[tag_tail] <= inst_addr;
        tag_tail         <= tag_nxt(tag_tail);
      end
      if (resp) begin
        tag_head <= tag_nxt(tag_head);
      end
      tag_cnt <= tag_cnt + TCW'(accept) - TCW'(resp);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_live),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer.
// Directed scenarios plus a randomized run against a queue-based model.
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;

  localparam logic [31:0] RPC = 32'hBFC00000;
  localparam int DEPTH = 4;
  localparam int MAXI  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_total = 0;
  int n_pass  = 0;

  inst_fetch_buffer #(
    .RESET_PC     (RPC),
    .FIFO_DEPTH   (DEPTH),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_wdata     (inst_wdata),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
  } tag_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  tag_t        m_tags[$];
  ent_t        m_fifo[$];
  logic [31:0] m_fetch = RPC;
  logic [31:0] m_hold_addr = '0;
  logic        m_hold = 1'b0;
  logic        m_stale = 1'b0;

  function automatic logic m_req();
    return !reset && (m_hold ||
      (m_tags.size() < MAXI && m_tags.size() + m_fifo.size() < DEPTH));
  endfunction

  function automatic logic [31:0] m_addr();
    return m_hold ? m_hold_addr : m_fetch;
  endfunction

  function automatic logic m_valid();
    return !reset && m_fifo.size() != 0;
  endfunction

  // One clock: model follows the inputs applied at the edge,
  // then control returns at the falling edge.
  task automatic tick();
    logic req, acc, fpop, stale_acc;
    logic [31:0] addr;
    tag_t t;
    req  = m_req();
    addr = m_addr();
    fpop = m_valid() && out_ready;
    @(posedge clk);
    if (reset) begin
      m_tags.delete();
      m_fifo.delete();
      m_fetch = RPC;
      m_hold = 1'b0;
      m_stale = 1'b0;
      m_hold_addr = '0;
    end else begin
      acc = req && inst_addr_ok;
      stale_acc = m_hold && m_stale;
      if (redirect_valid) begin
        foreach (m_tags[i]) begin
          t = m_tags[i];
          t.kill = 1'b1;
          m_tags[i] = t;
        end
      end
      if (fpop && !redirect_valid) void'(m_fifo.pop_front());
      if (inst_data_ok && m_tags.size() > 0) begin
        t = m_tags.pop_front();
        if (!t.kill) m_fifo.push_back('{pc: t.pc, inst: inst_rdata});
      end
      if (redirect_valid) m_fifo.delete();
      if (acc) m_tags.push_back('{pc: addr, kill: redirect_valid || stale_acc});
      if (redirect_valid) m_fetch = {redirect_pc[31:2], 2'b00};
      else if (acc && !stale_acc) m_fetch = addr + 32'd4;
      if (req && !inst_addr_ok) begin
        m_stale = stale_acc || redirect_valid;
        m_hold = 1'b1;
        m_hold_addr = addr;
      end else begin
        m_hold = 1'b0;
        m_stale = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    n_total++; if (inst_req !== 1'b0) $display("FAIL reset_req got %b want 0", inst_req); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", out_pc); else n_pass++;
    n_total++; if (out_inst !== 32'h0) $display("FAIL reset_inst got %h want 0", out_inst); else n_pass++;
    n_total++; if (inst_wr !== 1'b0) $display("FAIL const_wr got %b want 0", inst_wr); else n_pass++;
    n_total++; if (inst_size !== 2'b10) $display("FAIL const_size got %b want 10", inst_size); else n_pass++;
    n_total++; if (inst_wdata !== 32'h0) $display("FAIL const_wdata got %h want 0", inst_wdata); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (inst_req !== 1'b1) $display("FAIL rel_req got %b want 1", inst_req); else n_pass++;
    n_total++; if (inst_addr !== RPC) $display("FAIL rel_addr got %h want %h", inst_addr, RPC); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] pcs[$];
    int cyc[$];
    do_reset();
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inst_rdata = $urandom;
      tick();
      n_total++; if (out_valid !== m_valid()) $display("FAIL stream_valid got %b want %b", out_valid, m_valid()); else n_pass++;
      if (out_valid && m_fifo.size() != 0) begin
        n_total++; if (out_inst !== m_fifo[0].inst) $display("FAIL stream_inst got %h want %h", out_inst, m_fifo[0].inst); else n_pass++;
        pcs.push_back(out_pc);
        cyc.push_back(i);
      end
    end
    n_total++;
    if (pcs.size() < 3) $display("FAIL stream_count got %0d want >=3", pcs.size());
    else if (pcs[0] !== RPC || pcs[1] !== RPC + 4 || pcs[2] !== RPC + 8)
      $display("FAIL stream_seq got %h %h %h want %h %h %h", pcs[0], pcs[1], pcs[2], RPC, RPC + 4, RPC + 8);
    else if (cyc[1] != cyc[0] + 1 || cyc[2] != cyc[1] + 1)
      $display("FAIL stream_gap got cycles %0d %0d %0d want consecutive", cyc[0], cyc[1], cyc[2]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inst_rdata = $urandom;
      tick();
    end
    n_total++; if (inst_req !== 1'b0) $display("FAIL bp_req got %b want 0", inst_req); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", out_valid); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== RPC + 32'(4 * i))
        $display("FAIL bp_drain%0d got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, RPC + 32'(4 * i));
      else n_pass++;
      if (m_fifo.size() != 0) begin
        n_total++; if (out_inst !== m_fifo[0].inst) $display("FAIL bp_inst%0d got %h want %h", i, out_inst, m_fifo[0].inst); else n_pass++;
      end
      inst_rdata = $urandom;
      tick();
    end
  endtask

  task automatic test_redirect_inflight();
    logic found;
    do_reset();
    out_ready = 1'b1;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    tick();
    tick();
    n_total++; if (inst_req !== 1'b0) $display("FAIL rdi_req got %b want 0", inst_req); else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80001000;
    tick();
    redirect_valid = 1'b0;
    inst_data_ok = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      inst_rdata = $urandom;
      tick();
      if (out_valid) begin
        found = 1'b1;
        n_total++; if (out_pc !== 32'h80001000) $display("FAIL rdi_pc got %h want 80001000", out_pc); else n_pass++;
        if (m_fifo.size() != 0) begin
          n_total++; if (out_inst !== m_fifo[0].inst) $display("FAIL rdi_inst got %h want %h", out_inst, m_fifo[0].inst); else n_pass++;
        end
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL rdi_timeout got no out_valid want out_pc 80001000");
    end
  endtask

  task automatic test_redirect_pending();
    logic found;
    do_reset();
    out_ready = 1'b1;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80002003;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (inst_req !== 1'b1 || inst_addr !== RPC) $display("FAIL rdp_hold got req=%b addr=%h want 1 %h", inst_req, inst_addr, RPC); else n_pass++;
    inst_addr_ok = 1'b1;
    tick();
    n_total++; if (inst_req !== 1'b1 || inst_addr !== 32'h80002000) $display("FAIL rdp_next got req=%b addr=%h want 1 80002000", inst_req, inst_addr); else n_pass++;
    inst_data_ok = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      inst_rdata = $urandom;
      tick();
      if (out_valid) begin
        found = 1'b1;
        n_total++; if (out_pc !== 32'h80002000) $display("FAIL rdp_pc got %h want 80002000", out_pc); else n_pass++;
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL rdp_timeout got no out_valid want out_pc 80002000");
    end
  endtask

  task automatic test_redirect_collision();
    logic found;
    do_reset();
    out_ready = 1'b0;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_rdata = $urandom & ~32'h1;
      tick();
    end
    n_total++; if (out_valid !== 1'b1) $display("FAIL col_pre got %b want 1", out_valid); else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80003000;
    out_ready = 1'b1;
    inst_addr_ok = 1'b0;
    inst_rdata = 32'hDEADBEEF;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL col_flush got %b want 0", out_valid); else n_pass++;
    redirect_valid = 1'b0;
    inst_addr_ok = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      inst_rdata = $urandom & ~32'h1;
      tick();
      if (out_valid) begin
        found = 1'b1;
        n_total++; if (out_pc !== 32'h80003000) $display("FAIL col_pc got %h want 80003000", out_pc); else n_pass++;
        n_total++; if (out_inst === 32'hDEADBEEF) $display("FAIL col_word got %h want not deadbeef", out_inst); else n_pass++;
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL col_timeout got no out_valid want out_pc 80003000");
    end
  endtask

  task automatic test_spurious();
    do_reset();
    out_ready = 1'b1;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_rdata = $urandom;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL spur_valid%0d got %b want 0", i, out_valid); else n_pass++;
      n_total++; if (inst_addr !== RPC) $display("FAIL spur_addr%0d got %h want %h", i, inst_addr, RPC); else n_pass++;
    end
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    tick();
    n_total++; if (inst_addr !== RPC + 4) $display("FAIL spur_adv got %h want %h", inst_addr, RPC + 4); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL spur_end got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      inst_addr_ok   = ($urandom_range(0, 3) != 0);
      inst_data_ok   = ($urandom_range(0, 2) != 0);
      out_ready      = ((i / 150) % 2 == 1) ? ($urandom_range(0, 1) == 1)
                                             : ($urandom_range(0, 9) != 0);
      inst_rdata     = $urandom;
      tick();
      n_total++; if (inst_req !== m_req()) $display("FAIL rnd_req@%0d got %b want %b", i, inst_req, m_req()); else n_pass++;
      if (m_req()) begin
        n_total++; if (inst_addr !== m_addr()) $display("FAIL rnd_addr@%0d got %h want %h", i, inst_addr, m_addr()); else n_pass++;
      end
      n_total++; if (out_valid !== m_valid()) $display("FAIL rnd_valid@%0d got %b want %b", i, out_valid, m_valid()); else n_pass++;
      if (m_valid()) begin
        n_total++;
        if (out_pc !== m_fifo[0].pc || out_inst !== m_fifo[0].inst)
          $display("FAIL rnd_head@%0d got %h/%h want %h/%h", i, out_pc, out_inst, m_fifo[0].pc, m_fifo[0].inst);
        else n_pass++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pending();
    test_redirect_collision();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 Parameters SHALL be: RESET_PC, default 32'hBFC00000, first fetch address; FIFO_DEPTH, default 4, instruction FIFO entries; MAX_INFLIGHT, default 2, accepted-but-unanswered requests.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 redirect_valid  in  1  branch/exception redirect strobe.
REQ-006 redirect_pc  in  32  new fetch address; bits [1:0] SHALL be treated as zero.
REQ-007 inst_req / inst_wr / inst_size / inst_addr / inst_wdata  out  1/1/2/32/32  sram-like request to the AXI bridge; inst_wr=0, inst_size=2'b10, inst_wdata=0 constant.
REQ-008 inst_addr_ok / inst_data_ok  in  1/1  sram-like address accept / read data return.
REQ-009 inst_rdata  in  32  returned instruction word.
REQ-010 out_valid / out_ready  out/in  1/1  valid-ready handshake to decode.
REQ-011 out_pc / out_inst  out  32/32  PC and instruction at FIFO head.

Function
REQ-012 fetch_pc SHALL advance by 4 on every accepted request (inst_req & inst_addr_ok); inst_addr = fetch_pc.
REQ-013 inst_req SHALL assert only when inflight < MAX_INFLIGHT and inflight + fifo_count < FIFO_DEPTH (credit rule; FIFO can never overflow).
REQ-014 Once asserted, inst_req and inst_addr SHALL hold unchanged until inst_addr_ok, even across a redirect.
REQ-015 Each accepted request SHALL push {pc, kill=0} into an in-order inflight tag queue (MAX_INFLIGHT entries).
REQ-016 inst_data_ok SHALL pop the oldest tag; if kill=0, {pc, inst_rdata} is pushed into the FIFO; if kill=1 the word is discarded.
REQ-017 inst_data_ok with inflight==0 SHALL be ignored (no state change).
REQ-018 redirect_valid SHALL: load fetch_pc <= {redirect_pc[31:2],2'b00}; clear the FIFO; set kill on all inflight tags, on a tag accepted in the same cycle, and on a pending unaccepted request when it is later accepted.
REQ-019 data_ok in the redirect cycle SHALL be discarded; redirect overrides a same-cycle out_ready pop.
REQ-020 Same-cycle push (data_ok) and pop (out_valid & out_ready) SHALL both take effect, including when FIFO is full.
REQ-021 out_valid = FIFO non-empty; out_pc/out_inst driven from head register, no combinational path from inst_rdata.
REQ-022 Latency: redirect at T, no pending request, addr_ok immediate, data_ok at T+2 -> out_valid at T+3 with out_pc=redirect_pc.
REQ-023 Sustained throughput SHALL be one instruction per cycle when addr_ok/data_ok/out_ready are continuously high.

Reset
REQ-024 On reset: fetch_pc=RESET_PC, FIFO empty, inflight=0, all kill bits and pending-stale flag clear.
REQ-025 Outputs during/after reset cycle: inst_req=0, out_valid=0, out_pc=0, out_inst=0; inst_req may assert the cycle after reset deasserts.
REQ-026 Reset mid-transaction SHALL drop all tracking; the bridge is reset on the same signal, so no late data_ok is expected.

Structure
REQ-027 Shared package SHALL hold RESET_PC, inst_size encoding (2'b10), FIFO_DEPTH, MAX_INFLIGHT and the {pc,inst} entry typedef.
REQ-028 One sub-module, sync_fifo (parameterised width/depth, flush input, count output), SHALL implement the instruction FIFO; the tag queue stays inline.

Verification
REQ-029 Reset release, addr_ok/data_ok always 1, out_ready=1 -> out_pc sequence BFC00000, BFC00004, BFC00008 on consecutive cycles.
REQ-030 out_ready=0, responders always ready -> exactly 4 entries buffered, inst_req low thereafter; out_ready=1 -> four words drain in order, fetch resumes.
REQ-031 Two requests inflight (BFC00000, BFC00004), redirect to 80001000 before data_ok -> both responses dropped; first out_pc=80001000.
REQ-032 inst_req pending with addr_ok=0, redirect to 80002000, addr_ok one cycle later -> request at original address accepted then discarded; next inst_addr=80002000.
REQ-033 redirect coinciding with data_ok and out_ready pop -> FIFO empty next cycle, out_valid=0, returned word absent.
REQ-034 Spurious data_ok with inflight=0 -> out_valid stays 0, fetch_pc unchanged.
